// File: rtl/powergate_seq_pkg.sv
// rtl/powergate_seq_pkg.sv - state encoding and per-state control decode for the power-gate sequencer.
package powergate_seq_pkg;

  typedef enum logic [3:0] {
    ON, CLK_OFF, ISO_ON, RST_ON, SW_OFF, OFF, SW_ON, RST_OFF, ISO_OFF, CLK_ON, ERR
  } pg_state_e;

  typedef struct packed {
    logic switch_n;
    logic iso;
    logic rst_n;
    logic clk_en;
  } pg_ctrl_t;

  localparam pg_ctrl_t CTRL_ON      = '{switch_n: 1'b0, iso: 1'b0, rst_n: 1'b1, clk_en: 1'b1};
  localparam pg_ctrl_t CTRL_CLK_OFF = '{switch_n: 1'b0, iso: 1'b0, rst_n: 1'b1, clk_en: 1'b0};
  localparam pg_ctrl_t CTRL_ISO_ON  = '{switch_n: 1'b0, iso: 1'b1, rst_n: 1'b1, clk_en: 1'b0};
  localparam pg_ctrl_t CTRL_RST_ON  = '{switch_n: 1'b0, iso: 1'b1, rst_n: 1'b0, clk_en: 1'b0};
  localparam pg_ctrl_t CTRL_SW_OFF  = '{switch_n: 1'b1, iso: 1'b1, rst_n: 1'b0, clk_en: 1'b0};

  // Power-up mirrors power-down, so each up-step reuses a down-step pattern; ERR freezes.
  function automatic pg_ctrl_t pg_decode(input pg_state_e s, input pg_ctrl_t hold);
    case (s)
      ON, CLK_ON:       pg_decode = CTRL_ON;
      CLK_OFF, ISO_OFF: pg_decode = CTRL_CLK_OFF;
      ISO_ON, RST_OFF:  pg_decode = CTRL_ISO_ON;
      RST_ON, SW_ON:    pg_decode = CTRL_RST_ON;
      SW_OFF, OFF:      pg_decode = CTRL_SW_OFF;
      default:          pg_decode = hold;
    endcase
  endfunction

endpackage

// File: rtl/powergate_ack_sync.sv
// rtl/powergate_ack_sync.sv - two-flop synchronizer for the raw switch acknowledge, resets to 0.
module powergate_ack_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/powergate_seq_ctrl.sv
// rtl/powergate_seq_ctrl.sv - power-gate sequencer: clock/iso/reset/switch ordering with ack wait.
// Optional ack timeout and ERR state enabled by POWERGATE_SEQ_TIMEOUT_EN.
module powergate_seq_ctrl
  import powergate_seq_pkg::*;
#(
  parameter int STEP_WAIT   = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwr_on_req_i,
  input  logic clear_err_i,
  input  logic switch_ack_ni,
  output logic switch_no,
  output logic iso_o,
  output logic dom_rst_no,
  output logic clk_en_o,
  output logic on_o,
  output logic off_o,
  output logic busy_o,
  output logic err_o
);

  localparam int STEP_W = $clog2(STEP_WAIT + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_WAIT - 1);

  pg_state_e state_q, state_d, fail_state;
  pg_ctrl_t ctrl_q;
  logic [STEP_W-1:0] step_cnt;
  logic step_done, ack_s, ack_timeout, err_clear;

  powergate_ack_sync u_ack_sync (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .d    (switch_ack_ni),
    .q    (ack_s)
  );

  assign step_done = (step_cnt == STEP_LAST);

`ifdef POWERGATE_SEQ_TIMEOUT_EN
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  logic [ACK_W-1:0] ack_cnt;
  pg_state_e fail_q;
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_cnt <= '0;
      fail_q  <= SW_ON;
      err_q   <= 1'b0;
    end else begin
      if (state_d != state_q) ack_cnt <= '0;
      else if ((state_q == SW_OFF || state_q == SW_ON) && !ack_timeout) ack_cnt <= ack_cnt + 1'b1;
      if (state_d == ERR && state_q != ERR) fail_q <= state_q;
      err_q <= (state_d == ERR);
    end
  end

  assign ack_timeout = (ack_cnt == ACK_LAST);
  assign err_clear   = clear_err_i;
  assign fail_state  = fail_q;
  assign err_o       = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = clear_err_i | (ACK_TIMEOUT > 0);
  assign ack_timeout = 1'b0;
  assign err_clear   = 1'b0;
  assign fail_state  = ON;
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ON;
    else         state_q <= state_d;
  end

  // A matching ack takes priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ON:      if (!pwr_on_req_i) state_d = CLK_OFF;
      CLK_OFF: if (step_done) state_d = ISO_ON;
      ISO_ON:  if (step_done) state_d = RST_ON;
      RST_ON:  if (step_done) state_d = SW_OFF;
      SW_OFF:  if (ack_s) state_d = OFF;
               else if (ack_timeout) state_d = ERR;
      OFF:     if (pwr_on_req_i) state_d = SW_ON;
      SW_ON:   if (!ack_s) state_d = RST_OFF;
               else if (ack_timeout) state_d = ERR;
      RST_OFF: if (step_done) state_d = ISO_OFF;
      ISO_OFF: if (step_done) state_d = CLK_ON;
      CLK_ON:  if (step_done) state_d = ON;
      ERR:     if (err_clear) state_d = fail_state;
      default: state_d = ON;
    endcase
  end

  // Outputs decode the next state so each action appears on the edge that enters its step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_cnt <= '0;
      ctrl_q   <= CTRL_ON;
      on_o     <= 1'b1;
      off_o    <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      if (state_d != state_q) step_cnt <= '0;
      else if (!step_done)    step_cnt <= step_cnt + 1'b1;
      ctrl_q <= pg_decode(state_d, ctrl_q);
      on_o   <= (state_d == ON);
      off_o  <= (state_d == OFF);
      busy_o <= !(state_d == ON || state_d == OFF || state_d == ERR);
    end
  end

  assign switch_no  = ctrl_q.switch_n;
  assign iso_o      = ctrl_q.iso;
  assign dom_rst_no = ctrl_q.rst_n;
  assign clk_en_o   = ctrl_q.clk_en;

endmodule

// File: tb/tb_powergate_seq_ctrl.sv
// tb/tb_powergate_seq_ctrl.sv - directed bench with a 16-stage delayed-ack emulator.
module tb_powergate_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n, req, clear;
  logic switch_ack_n, switch_n, iso, dom_rst_n, clk_en, on, off, busy, err;
  logic [15:0] emu;
  logic force_en, force_val;
  logic [7:0] outs;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  powergate_seq_ctrl #(.STEP_WAIT(2), .ACK_TIMEOUT(64)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pwr_on_req_i (req),
    .clear_err_i  (clear),
    .switch_ack_ni(switch_ack_n),
    .switch_no    (switch_n),
    .iso_o        (iso),
    .dom_rst_no   (dom_rst_n),
    .clk_en_o     (clk_en),
    .on_o         (on),
    .off_o        (off),
    .busy_o       (busy),
    .err_o        (err)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) emu <= '0;
    else        emu <= {emu[14:0], switch_n};
  end
  assign switch_ack_n = force_en ? force_val : emu[15];

  // {switch_no, iso, dom_rst_n, clk_en, on, off, busy, err}
  assign outs = {switch_n, iso, dom_rst_n, clk_en, on, off, busy, err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input string tag, input bit want_on, input int budget);
    int n = 0;
    while (((want_on ? on : off) !== 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, (want_on ? on : off)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 1'b1; clear = 1'b0; force_en = 1'b0; force_val = 1'b0;
    ticks(2);
    check("reset_outs", outs, 8'h38);
    rst_n = 1'b1;
    ticks(2);
    check("on_idle", outs, 8'h38);

    // power-down, E0 is the first edge after req drops
    req = 1'b0;
    tick(); check("dn_E0_clk_off", outs, 8'h22);
    tick(); check("dn_E1_clk_off", outs, 8'h22);
    tick(); check("dn_E2_iso_on", outs, 8'h62);
    ticks(2); check("dn_E4_rst_on", outs, 8'h42);
    ticks(2); check("dn_E6_sw_off", outs, 8'hC2);
    ticks(18); check("dn_E24_wait", outs, 8'hC2);
    tick(); check("dn_E25_off", outs, 8'hC4);
    tick(); check("off_hold", outs, 8'hC4);

    // power-up
    req = 1'b1;
    tick(); check("up_E0_sw_on", outs, 8'h42);
    ticks(18); check("up_E18_wait", outs, 8'h42);
    tick(); check("up_E19_rst_off", outs, 8'h62);
    ticks(2); check("up_E21_iso_off", outs, 8'h22);
    ticks(2); check("up_E23_clk_on", outs, 8'h32);
    tick(); check("up_E24_clk_on", outs, 8'h32);
    tick(); check("up_E25_on", outs, 8'h38);

    // request flips back during RST_ON
    req = 1'b0;
    tick(); check("tg_E0", outs, 8'h22);
    ticks(4); check("tg_E4_rst_on", outs, 8'h42);
    req = 1'b1;
    ticks(2); check("tg_E6_sw_off", outs, 8'hC2);
    ticks(19); check("tg_E25_off", outs, 8'hC4);
    tick(); check("tg_E26_sw_on", outs, 8'h42);
    wait_state("tg_reach_on", 1'b1, 100);

    // ack already matching on entry to SW_ON
    req = 1'b0;
    wait_state("pre_off", 1'b0, 100);
    force_en = 1'b1; force_val = 1'b0;
    ticks(3); check("pre_off_hold", outs, 8'hC4);
    req = 1'b1;
    tick(); check("fast_E0_sw_on", outs, 8'h42);
    tick(); check("fast_E1_rst_off", outs, 8'h62);
    wait_state("fast_reach_on", 1'b1, 50);
    force_en = 1'b0;
    ticks(20);

    // asynchronous reset while in SW_OFF
    req = 1'b0;
    tick(); ticks(6); check("ar_sw_off", outs, 8'hC2);
    tick();
    #1 rst_n = 1'b0;
    #1 check("ar_async_outs", outs, 8'h38);
    req = 1'b1;
    ticks(2);
    rst_n = 1'b1;
    tick(); check("ar_after_rel", outs, 8'h38);
    ticks(3); check("ar_stays_on", outs, 8'h38);

`ifdef POWERGATE_SEQ_TIMEOUT_EN
    req = 1'b0;
    wait_state("to_off", 1'b0, 100);
    force_en = 1'b1; force_val = 1'b1;
    req = 1'b1;
    tick(); check("to_E0_sw_on", outs, 8'h42);
    ticks(63); check("to_E63_wait", outs, 8'h42);
    tick(); check("to_E64_err", outs, 8'h41);
    ticks(5); check("to_err_frozen", outs, 8'h41);
    force_val = 1'b0;
    ticks(3); check("to_err_ack_ok", outs, 8'h41);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("to_clear_sw_on", outs, 8'h42);
    tick(); check("to_rst_off", outs, 8'h62);
    wait_state("to_reach_on", 1'b1, 50);
    check("to_final", outs, 8'h38);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
